// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the ring-oscillator PUF measurement engine.
package puf_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, RESULT} state_t;

    function automatic int pair_cnt(input int n);
        return n / 2;
    endfunction

    function automatic longint unsigned cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/puf_edge_sync.sv
// Two-flop synchroniser for one oscillator line plus a one-cycle rising-edge strobe.
module puf_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ro,
    output logic rise
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], ro};
            r_prev <= r_sync[1];
        end
    end

    assign rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/puf_ro_meter.sv
// Ring-oscillator PUF meter: settle, count edges per channel over a window,
// then compare adjacent channel pairs into a response word.
module puf_ro_meter
    import puf_pkg::*;
#(
    parameter int NUM_RO     = 8,
    parameter int CNT_W      = 20,
    parameter int WIN_W      = 20,
    parameter int SETTLE_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIN_W-1:0]            win_len,
    input  logic [NUM_RO-1:0]           ro_in,
    output logic                        ro_en,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_RO*CNT_W-1:0]     counts,
    output logic [pair_cnt(NUM_RO)-1:0] response,
    output logic [pair_cnt(NUM_RO)-1:0] tie,
    output logic [NUM_RO-1:0]           sat
);

    localparam int NP    = pair_cnt(NUM_RO);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    state_t                         r_state, w_state_nxt;
    logic [WIN_W-1:0]               r_win;
    logic [TMR_W-1:0]               r_tmr;
    logic                           w_tmr_clr;
    logic                           w_accept;
    logic [NUM_RO-1:0]              w_rise;
    logic [NUM_RO-1:0][CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NUM_RO-1:0]              r_sat, w_sat_nxt;
    logic [NP-1:0]                  r_resp, r_tie, w_resp, w_tie;
    logic                           r_ro_en, r_busy, r_done;

    for (genvar g = 0; g < NUM_RO; g++) begin : g_ch
        puf_edge_sync u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .ro   (ro_in[g]),
            .rise (w_rise[g])
        );
    end

    assign w_accept = (r_state == IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SETTLE;
                    w_tmr_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (r_tmr == TMR_W'(SETTLE_CYC - 1)) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = (r_win == '0) ? RESULT : MEASURE;
                end
            end
            MEASURE: begin
                if (r_tmr + TMR_W'(1) == TMR_W'(r_win)) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = RESULT;
                end
            end
            RESULT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Comparators look at next-cycle counts so the last window edge is included
    // in the response that is latched on entry to RESULT.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_sat_nxt = r_sat;
        for (int i = 0; i < NUM_RO; i++) begin
            if (r_state == MEASURE && w_rise[i] && r_cnt[i] != CNT_MAX)
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            if (w_cnt_nxt[i] == CNT_MAX)
                w_sat_nxt[i] = 1'b1;
        end
        for (int j = 0; j < NP; j++) begin
            w_resp[j] = w_cnt_nxt[2*j] > w_cnt_nxt[2*j+1];
            w_tie[j]  = w_cnt_nxt[2*j] == w_cnt_nxt[2*j+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_sat   <= '0;
            r_resp  <= '0;
            r_tie   <= '0;
            r_ro_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ro_en <= (w_state_nxt == SETTLE) || (w_state_nxt == MEASURE);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == RESULT);
            if (w_tmr_clr)
                r_tmr <= '0;
            else if (r_state != IDLE)
                r_tmr <= r_tmr + TMR_W'(1);
            if (w_accept) begin
                r_win  <= win_len;
                r_cnt  <= '0;
                r_sat  <= '0;
                r_resp <= '0;
                r_tie  <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_sat <= w_sat_nxt;
                if (w_state_nxt == RESULT && r_state != RESULT) begin
                    r_resp <= w_resp;
                    r_tie  <= w_tie;
                end
            end
        end
    end

    assign ro_en    = r_ro_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign counts   = r_cnt;
    assign response = r_resp;
    assign tie      = r_tie;
    assign sat      = r_sat;

endmodule

// File: tb/tb_puf_ro_meter.sv
// Directed bench for puf_ro_meter: table of measurement vectors plus hand-written
// sequences for reset, start-while-busy and asynchronous abort.
module tb_puf_ro_meter;

    localparam int NUM_RO = 4;
    localparam int CNT_W  = 4;
    localparam int WIN_W  = 8;
    localparam int SET_C  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [WIN_W-1:0]        win_len = '0;
    logic [NUM_RO-1:0]       ro_in = '0;
    logic                    ro_en, busy, done;
    logic [NUM_RO*CNT_W-1:0] counts;
    logic [1:0]              response, tie;
    logic [NUM_RO-1:0]       sat;

    int checks = 0;
    int errors = 0;
    int per [NUM_RO];
    int ph  [NUM_RO];

    puf_ro_meter #(
        .NUM_RO(NUM_RO), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SET_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .ro_in(ro_in),
        .ro_en(ro_en), .busy(busy), .done(done), .counts(counts),
        .response(response), .tie(tie), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic int ph_next(input int p, input int q);
        return (q == 0 || p + 1 >= q) ? 0 : p + 1;
    endfunction

    // Oscillator models: period per[i] clk cycles, about half high; 0 = idle low.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_RO; i++) begin
            ph[i]    <= ph_next(ph[i], per[i]);
            ro_in[i] <= (per[i] != 0) && (ph_next(ph[i], per[i]) < per[i] / 2);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0]      win;
        logic [3:0][7:0] per;
        logic [3:0][3:0] cnt;
        logic [1:0]      resp;
        logic [1:0]      tie;
        logic [3:0]      sat;
    } vec_t;

    vec_t vt [5];

    function automatic vec_t mk(input int w, input int p0, input int p1, input int p2,
                                input int p3, input int c0, input int c1, input int c2,
                                input int c3, input logic [1:0] rs, input logic [1:0] ti,
                                input logic [3:0] st);
        vec_t v;
        v.win  = 8'(w);
        v.per  = {8'(p3), 8'(p2), 8'(p1), 8'(p0)};
        v.cnt  = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
        v.resp = rs;
        v.tie  = ti;
        v.sat  = st;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_per(input logic [3:0][7:0] p);
        for (int i = 0; i < NUM_RO; i++) per[i] = int'(p[i]);
    endtask

    // Raise start at a negedge and count edges (the accepting edge is 1) until done.
    task automatic run(input int w, input bit keep_start, output int lat);
        @(negedge clk);
        win_len = 8'(w);
        start   = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        while (!done && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic apply(input vec_t v, input string nm);
        int lat;
        set_per(v.per);
        repeat (40) @(negedge clk);
        run(int'(v.win), 1'b0, lat);
        chk({nm, "_latency"}, lat, SET_C + int'(v.win) + 1);
        for (int i = 0; i < NUM_RO; i++)
            chk($sformatf("%s_count%0d", nm, i), int'(counts[i*CNT_W +: CNT_W]), int'(v.cnt[i]));
        chk({nm, "_response"}, int'(response), int'(v.resp));
        chk({nm, "_tie"}, int'(tie), int'(v.tie));
        chk({nm, "_sat"}, int'(sat), int'(v.sat));
        chk({nm, "_busy_in_done"}, int'(busy), 1);
        chk({nm, "_ro_en_in_done"}, int'(ro_en), 0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, int'(done), 0);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_hold_count0"}, int'(counts[0 +: CNT_W]), int'(v.cnt[0]));
    endtask

    initial begin
        int lat;
        int extra;
        vt[0] = mk(96,  8, 12,  0,  0, 12,  8,  0,  0, 2'b01, 2'b10, 4'b0000);
        vt[1] = mk(100, 0,  0, 10, 10,  0,  0, 10, 10, 2'b00, 2'b11, 4'b0000);
        vt[2] = mk(100, 5, 10, 20,  0, 15, 10,  5,  0, 2'b11, 2'b00, 4'b0001);
        vt[3] = mk(0,   5, 10, 20,  0,  0,  0,  0,  0, 2'b00, 2'b11, 4'b0000);
        vt[4] = mk(60,  6,  6, 12, 15, 10, 10,  5,  4, 2'b10, 2'b01, 4'b0000);
        for (int i = 0; i < NUM_RO; i++) begin
            per[i] = 5 + i;
            ph[i]  = 0;
        end

        // Reset held with oscillators toggling.
        repeat (8) @(negedge clk);
        chk("rst_ro_en", int'(ro_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_counts", int'(counts), 0);
        chk("rst_response", int'(response), 0);
        chk("rst_tie", int'(tie), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) apply(vt[v], $sformatf("vec%0d", v));

        // start held through done: ignored in RESULT, accepted one cycle later.
        run(0, 1'b1, lat);
        chk("hold_latency", lat, SET_C + 1);
        @(negedge clk);
        chk("hold_ignored_in_result", int'(busy), 0);
        @(negedge clk);
        chk("hold_accepted_next", int'(busy), 1);
        start = 1'b0;
        win_len = 8'd20;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("pulsed_done_seen", int'(done), 1);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        chk("no_second_measure", extra, 0);

        // Asynchronous abort mid-MEASURE.
        set_per(vt[0].per);
        repeat (40) @(negedge clk);
        win_len = 8'd96;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ro_en", int'(ro_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_counts", int'(counts), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(vt[0], "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
